// File: rtl/uart_writer_pkg.sv
// Shared types and helpers for the UART block writer.
// State encoding, byte width and a width helper.
package uart_writer_pkg;

   localparam int BYTE_W = 8;

   typedef enum logic [1:0] {
      IDLE,
      SKIP,
      LOAD,
      DONE
   } state_t;

   // Index width for n values, never below one bit.
   function automatic int clog2(input int n);
      int r;
      r = 1;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/uart_block_writer_packer.sv
// Byte packer: assembles lanes into a word and emits a
// one-cycle word_valid with the registered word.
module byte_packer
   import uart_writer_pkg::*;
#(
   parameter int BPW = 1,
   parameter bit LE  = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clear,
   input  logic                  tick,
   input  logic [BYTE_W-1:0]     data,
   output logic                  word_valid,
   output logic [BPW*BYTE_W-1:0] word
);

   localparam int LW = clog2(BPW);
   localparam logic [LW-1:0] LAST_LANE = LW'(BPW - 1);

   logic [LW-1:0]         lane_cnt;
   logic [LW-1:0]         pos;
   logic [BPW*BYTE_W-1:0] asm_q;
   logic [BPW*BYTE_W-1:0] asm_n;
   logic                  last;

   assign last = (lane_cnt == LAST_LANE);
   assign pos  = LE ? lane_cnt : LAST_LANE - lane_cnt;

   always_comb begin
      asm_n = asm_q;
      asm_n[pos*BYTE_W +: BYTE_W] = data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lane_cnt   <= '0;
         asm_q      <= '0;
         word       <= '0;
         word_valid <= 1'b0;
      end else begin
         word_valid <= 1'b0;
         if (clear) begin
            lane_cnt <= '0;
            asm_q    <= '0;
         end else if (tick) begin
            if (last) begin
               lane_cnt   <= '0;
               asm_q      <= '0;
               word       <= asm_n;
               word_valid <= 1'b1;
            end else begin
               lane_cnt <= lane_cnt + 1'b1;
               asm_q    <= asm_n;
            end
         end
      end
   end

endmodule

// File: rtl/uart_block_writer.sv
// UART-to-RAM loader: skips a header, packs bytes into
// words and writes DEPTH words from address 0.
module uart_block_writer
   import uart_writer_pkg::*;
#(
   parameter int BYTES_PER_WORD = 1,
   parameter int ADDR_W         = 16,
   parameter int DEPTH          = 65536,
   parameter int HEADER_BYTES   = 16,
   parameter bit LITTLE_ENDIAN  = 1'b1
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             start,
   input  logic                             rx_tick,
   input  logic [BYTE_W-1:0]                rx_data,
   output logic                             wen,
   output logic [ADDR_W-1:0]                waddr,
   output logic [BYTE_W*BYTES_PER_WORD-1:0] wdata,
   output logic                             busy,
   output logic                             fin
);

   localparam int HW = clog2(HEADER_BYTES + 1);
   localparam logic [HW-1:0]   HDR_LAST = HW'(HEADER_BYTES - 1);
   localparam logic [ADDR_W:0] LAST     = (ADDR_W + 1)'(DEPTH - 1);

   state_t          state;
   logic [HW-1:0]   hdr_cnt;
   logic [ADDR_W:0] word_cnt;
   logic            pk_tick;

   // Extra counter bit keeps DEPTH = 2**ADDR_W from wrapping.
   assign waddr   = word_cnt[ADDR_W-1:0];
   assign pk_tick = rx_tick && (state == LOAD) && !start;

   byte_packer #(
      .BPW (BYTES_PER_WORD),
      .LE  (LITTLE_ENDIAN)
   ) u_packer (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear      (start),
      .tick       (pk_tick),
      .data       (rx_data),
      .word_valid (wen),
      .word       (wdata)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         hdr_cnt  <= '0;
         word_cnt <= '0;
         busy     <= 1'b0;
         fin      <= 1'b0;
      end else if (start) begin
         state    <= (HEADER_BYTES > 0) ? SKIP : LOAD;
         hdr_cnt  <= '0;
         word_cnt <= '0;
         busy     <= 1'b1;
         fin      <= 1'b0;
      end else begin
         unique case (state)
            SKIP: begin
               if (rx_tick) begin
                  if (hdr_cnt == HDR_LAST) begin
                     state   <= LOAD;
                     hdr_cnt <= '0;
                  end else begin
                     hdr_cnt <= hdr_cnt + 1'b1;
                  end
               end
            end
            LOAD: begin
               if (wen) begin
                  if (word_cnt == LAST) begin
                     state    <= DONE;
                     word_cnt <= '0;
                     busy     <= 1'b0;
                     fin      <= 1'b1;
                  end else begin
                     word_cnt <= word_cnt + 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_block_writer.sv
// Directed bench with write scoreboards for three
// configurations of uart_block_writer.
module tb_uart_block_writer;

   logic clk = 1'b0;
   logic rst_n;
   logic start_ab, tick_ab, start_c, tick_c;
   logic [7:0] data_ab, data_c;

   logic        wen_a, busy_a, fin_a;
   logic [15:0] waddr_a, wdata_a;
   logic        wen_b, busy_b, fin_b;
   logic [15:0] waddr_b, wdata_b;
   logic        wen_c, busy_c, fin_c;
   logic [3:0]  waddr_c;
   logic [7:0]  wdata_c;

   int checks = 0;
   int errors = 0;
   logic [31:0] qa[$];
   logic [31:0] qb[$];
   logic [31:0] qc[$];

   always #5 clk = ~clk;

   uart_block_writer #(
      .BYTES_PER_WORD(2), .ADDR_W(16), .DEPTH(4),
      .HEADER_BYTES(3), .LITTLE_ENDIAN(1'b1)
   ) dut_a (
      .clk(clk), .rst_n(rst_n), .start(start_ab),
      .rx_tick(tick_ab), .rx_data(data_ab),
      .wen(wen_a), .waddr(waddr_a), .wdata(wdata_a),
      .busy(busy_a), .fin(fin_a)
   );

   uart_block_writer #(
      .BYTES_PER_WORD(2), .ADDR_W(16), .DEPTH(4),
      .HEADER_BYTES(3), .LITTLE_ENDIAN(1'b0)
   ) dut_b (
      .clk(clk), .rst_n(rst_n), .start(start_ab),
      .rx_tick(tick_ab), .rx_data(data_ab),
      .wen(wen_b), .waddr(waddr_b), .wdata(wdata_b),
      .busy(busy_b), .fin(fin_b)
   );

   uart_block_writer #(
      .BYTES_PER_WORD(1), .ADDR_W(4), .DEPTH(16),
      .HEADER_BYTES(0), .LITTLE_ENDIAN(1'b1)
   ) dut_c (
      .clk(clk), .rst_n(rst_n), .start(start_c),
      .rx_tick(tick_c), .rx_data(data_c),
      .wen(wen_c), .waddr(waddr_c), .wdata(wdata_c),
      .busy(busy_c), .fin(fin_c)
   );

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Scoreboards: an unexpected write pops 'x and so fails.
   always @(negedge clk) begin
      logic [31:0] e;
      if (rst_n && wen_a) begin
         e = (qa.size() != 0) ? qa.pop_front() : 'x;
         chk("wr_a", {waddr_a, wdata_a}, e);
      end
      if (rst_n && wen_b) begin
         e = (qb.size() != 0) ? qb.pop_front() : 'x;
         chk("wr_b", {waddr_b, wdata_b}, e);
      end
      if (rst_n && wen_c) begin
         e = (qc.size() != 0) ? qc.pop_front() : 'x;
         chk("wr_c", {20'h0, waddr_c, wdata_c}, e);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic tick_abt(input logic [7:0] b);
      tick_ab = 1'b1;
      data_ab = b;
      step();
      tick_ab = 1'b0;
   endtask

   task automatic tick_ct(input logic [7:0] b);
      tick_c = 1'b1;
      data_c = b;
      step();
      tick_c = 1'b0;
   endtask

   task automatic start_abt(input logic tk, input logic [7:0] b);
      start_ab = 1'b1;
      tick_ab  = tk;
      data_ab  = b;
      step();
      start_ab = 1'b0;
      tick_ab  = 1'b0;
   endtask

   task automatic start_ct();
      start_c = 1'b1;
      step();
      start_c = 1'b0;
   endtask

   initial begin
      rst_n    = 1'b0;
      start_ab = 1'b0;
      tick_ab  = 1'b0;
      data_ab  = 8'h00;
      start_c  = 1'b0;
      tick_c   = 1'b0;
      data_c   = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_wen", 32'(wen_a), 0);
      chk("rst_waddr", 32'(waddr_a), 0);
      chk("rst_wdata", 32'(wdata_a), 0);
      chk("rst_busy", 32'(busy_a), 0);
      chk("rst_fin", 32'(fin_a), 0);
      rst_n = 1'b1;
      step();

      // LE and BE packing, 3-byte header
      for (int i = 0; i < 4; i++) begin
         qa.push_back({16'(i), 8'(4 + 2 * i), 8'(3 + 2 * i)});
         qb.push_back({16'(i), 8'(3 + 2 * i), 8'(4 + 2 * i)});
      end
      start_abt(1'b0, 8'h00);
      chk("arm_busy", 32'(busy_a), 1);
      for (int i = 0; i <= 10; i++) tick_abt(8'(i));
      chk("last_wen", 32'(wen_a), 1);
      chk("last_fin_lo", 32'(fin_a), 0);
      step();
      chk("fin_a", 32'(fin_a), 1);
      chk("fin_b", 32'(fin_b), 1);
      chk("done_busy", 32'(busy_a), 0);
      chk("done_waddr", 32'(waddr_a), 0);
      chk("done_wen", 32'(wen_a), 0);
      chk("qa_empty", 32'(qa.size()), 0);
      chk("qb_empty", 32'(qb.size()), 0);

      // Abort after 5 payload bytes; start beats a tick
      qa.push_back({16'd0, 16'h2120});
      qa.push_back({16'd1, 16'h2322});
      qb.push_back({16'd0, 16'h2021});
      qb.push_back({16'd1, 16'h2223});
      start_abt(1'b0, 8'h00);
      for (int i = 0; i < 3; i++) tick_abt(8'h30);
      for (int i = 0; i < 5; i++) tick_abt(8'(8'h20 + i));
      start_abt(1'b1, 8'h25);
      chk("abort_waddr", 32'(waddr_a), 0);
      chk("abort_fin", 32'(fin_a), 0);
      for (int i = 0; i < 4; i++) begin
         qa.push_back({16'(i), 8'(8'h41 + 2 * i), 8'(8'h40 + 2 * i)});
         qb.push_back({16'(i), 8'(8'h40 + 2 * i), 8'(8'h41 + 2 * i)});
      end
      for (int i = 0; i < 3; i++) tick_abt(8'h31);
      for (int i = 0; i < 8; i++) tick_abt(8'(8'h40 + i));
      step();
      chk("reload_fin", 32'(fin_a), 1);
      chk("qa_empty2", 32'(qa.size()), 0);
      chk("qb_empty2", 32'(qb.size()), 0);

      // Back-to-back ticks, then async reset mid-load
      for (int i = 0; i < 8; i++) qc.push_back({20'h0, 4'(i), 8'(8'h10 + i)});
      start_ct();
      for (int i = 0; i < 8; i++) tick_ct(8'(8'h10 + i));
      step();
      chk("qc_b2b", 32'(qc.size()), 0);
      chk("mid_busy", 32'(busy_c), 1);
      #3 rst_n = 1'b0;
      #1;
      chk("ar_wen", 32'(wen_c), 0);
      chk("ar_waddr", 32'(waddr_c), 0);
      chk("ar_wdata", 32'(wdata_c), 0);
      chk("ar_busy", 32'(busy_c), 0);
      chk("ar_fin", 32'(fin_c), 0);
      step();
      rst_n = 1'b1;
      step();
      tick_ct(8'h77);
      tick_ct(8'h78);
      step();
      chk("idle_busy", 32'(busy_c), 0);

      // Full 16-word load, extra ticks, start in DONE
      for (int i = 0; i < 16; i++) qc.push_back({20'h0, 4'(i), 8'(8'h50 + i)});
      start_ct();
      for (int i = 0; i < 16; i++) tick_ct(8'(8'h50 + i));
      chk("full_wen", 32'(wen_c), 1);
      chk("full_waddr", 32'(waddr_c), 15);
      step();
      chk("full_fin", 32'(fin_c), 1);
      chk("full_wrap", 32'(waddr_c), 0);
      tick_ct(8'hEE);
      tick_ct(8'hEF);
      step();
      chk("post_wen", 32'(wen_c), 0);
      start_ct();
      chk("rearm_fin", 32'(fin_c), 0);
      chk("rearm_busy", 32'(busy_c), 1);
      chk("qc_empty", 32'(qc.size()), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
